cache_fill_fsm: RTL and testbench

//  Miss-handling engine that services the cache's miss_detected output and drives its fill-side write strobes.
//  On a miss it latches the block address, issues WORDS_PER_BLOCK pipelined word reads to main memory,
//  and writes each returned word into the data array. It then writes the tag/valid/LRU metadata once.
//  One instance sits beside each cache (I and D); arbiter grants memory access upstream of this block.

---
 rtl/cache_fill_fsm.sv | 126 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill engine: pipelined block read from memory, data writes, then one tag write
// Optional critical-word-first ordering is enabled by defining CACHE_FILL_WRAP_EN.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int OFFSET_BITS     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic [15:0]           memory_data,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] fill_address,
    output logic [15:0]           fill_data
);

    localparam int IDX_W = OFFSET_BITS - 1;
    localparam logic [OFFSET_BITS-1:0] WPB      = OFFSET_BITS'(WORDS_PER_BLOCK);
    localparam logic [OFFSET_BITS-1:0] LAST     = OFFSET_BITS'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0]  OFF_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TAG
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_WIDTH-1:0]  base;
    logic [OFFSET_BITS-1:0] req_cnt;
    logic [OFFSET_BITS-1:0] rsp_cnt;
    logic [IDX_W-1:0]       start;
    logic                   req_fire;
    logic                   rsp_fire;

    // Word index wraps inside the block; the sum with the aligned base wraps mod 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] blk,
                                                        input logic [IDX_W-1:0]      first,
                                                        input logic [IDX_W-1:0]      k);
        logic [IDX_W-1:0] idx;
        idx = first + k;
        return blk + ADDR_WIDTH'({idx, 1'b0});
    endfunction

`ifdef CACHE_FILL_WRAP_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            start <= '0;
        end else if (state == IDLE && miss_detected) begin
            start <= miss_address[OFFSET_BITS-1:1];
        end
    end
`else
    assign start = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            base    <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base    <= miss_address & ~OFF_MASK;
                        req_cnt <= '0;
                        rsp_cnt <= '0;
                    end
                end
                FILL: begin
                    if (req_fire) req_cnt <= req_cnt + OFFSET_BITS'(1);
                    if (rsp_fire) rsp_cnt <= rsp_cnt + OFFSET_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    // The fire terms are gated by the counter limits, so both counters saturate at WPB.
    always_comb begin
        state_nxt        = state;
        fsm_busy         = 1'b0;
        mem_rd_en        = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_address     = '0;
        fill_data        = '0;
        req_fire         = 1'b0;
        rsp_fire         = 1'b0;
        case (state)
            IDLE: begin
                if (miss_detected) state_nxt = FILL;
            end
            FILL: begin
                fsm_busy         = 1'b1;
                req_fire         = (req_cnt < WPB);
                mem_rd_en        = req_fire;
                memory_address   = word_addr(base, start, req_cnt[IDX_W-1:0]);
                rsp_fire         = memory_data_valid && (rsp_cnt < WPB);
                write_data_array = rsp_fire;
                fill_address     = word_addr(base, start, rsp_cnt[IDX_W-1:0]);
                fill_data        = memory_data;
                if (rsp_fire && rsp_cnt == LAST) state_nxt = TAG;
            end
            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                fill_address    = base;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - randomized self-checking bench for cache_fill_fsm against a block-fill reference model
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_rd_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] fill_address;
    logic [15:0] fill_data;

    int checks = 0;
    int errors = 0;

`ifdef CACHE_FILL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data      (memory_data),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_rd_en        (mem_rd_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .fill_address     (fill_address),
        .fill_data        (fill_data)
    );

    always #5 clk = ~clk;

    logic [51:0] all_out;
    assign all_out = {fsm_busy, mem_rd_en, write_data_array, write_tag_array,
                      memory_address, fill_address, fill_data};

    // Reference: word k of a fill lives at aligned base + 2*((start+k) mod 8).
    function automatic logic [15:0] exp_addr(input logic [15:0] m, input int k);
        int b;
        int st;
        b  = int'(m & 16'hFFF0);
        st = WRAP ? int'(m[3:1]) : 0;
        return 16'(b + 2 * ((st + k) % 8));
    endfunction

    function automatic logic [15:0] exp_base(input logic [15:0] m);
        return m & 16'hFFF0;
    endfunction

    logic [15:0] req_a[$];
    int          req_c[$];
    logic [15:0] wr_a[$];
    logic [15:0] wr_d[$];
    logic [15:0] sent[$];
    int          tag_cyc;
    int          last_beat;
    logic [15:0] tag_addr;
    logic        tag_wde;
    logic        tag_busy;
    logic        timed_out;
    logic [51:0] out0;

    // Drives one miss and plays memory; mode 0 = beat when due, 1 = even cycles only, 2 = random gaps.
    task automatic do_fill(input logic [15:0] maddr, input int mode, input int lat);
        int cyc;
        int beats;
        int due[$];
        bit tag_seen;
        bit give;
        req_a.delete(); req_c.delete(); wr_a.delete(); wr_d.delete(); sent.delete();
        cyc = 0; beats = 0; tag_seen = 1'b0; tag_cyc = -1; last_beat = -1;
        @(negedge clk);
        miss_detected = 1'b1; miss_address = maddr; memory_data_valid = 1'b0;
        #1 out0 = all_out;
        while (!tag_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            miss_detected     = 1'($urandom);
            miss_address      = 16'($urandom);
            memory_data       = 16'($urandom);
            memory_data_valid = 1'b0;
            give = (mode == 0) || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom % 2 == 1);
            if (beats == 8) begin
                memory_data_valid = 1'b1;
            end else if (due.size() > 0 && due[0] <= cyc && give) begin
                void'(due.pop_front());
                memory_data_valid = 1'b1;
                sent.push_back(memory_data);
                beats++;
                last_beat = cyc;
            end
            #1;
            if (mem_rd_en) begin
                req_a.push_back(memory_address);
                req_c.push_back(cyc);
                due.push_back(cyc + lat + (mode == 2 ? int'($urandom % 3) : 0));
            end
            if (write_data_array) begin
                wr_a.push_back(fill_address);
                wr_d.push_back(fill_data);
            end
            if (write_tag_array) begin
                tag_seen = 1'b1;
                tag_cyc  = cyc;
                tag_addr = fill_address;
                tag_wde  = write_data_array;
                tag_busy = fsm_busy;
            end
        end
        timed_out = !tag_seen;
        memory_data_valid = 1'b0;
        miss_detected = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; miss_detected = 1'b1; miss_address = 16'h1A36; memory_data_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (all_out !== '0) begin
                errors++; $display("FAIL reset_outputs got %h want 0", all_out);
            end
        end
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (mem_rd_en !== 1'b0 || fsm_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle got rd=%b busy=%b want 0 0", mem_rd_en, fsm_busy);
        end
        @(negedge clk); #1;
        checks++;
        if (mem_rd_en !== 1'b1 || memory_address !== exp_addr(16'h1A36, 0)) begin
            errors++; $display("FAIL reset_first_req got rd=%b addr=%h want 1 %h", mem_rd_en, memory_address, exp_addr(16'h1A36, 0));
        end
        @(negedge clk); rst = 1'b0; miss_detected = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_abort_idle got %h want 0", all_out);
        end
    endtask

    task automatic test_fill_basic;
        do_fill(16'h1A36, 0, 4);
        checks++;
        if (timed_out || out0 !== '0) begin
            errors++; $display("FAIL basic_start got timeout=%b out0=%h want 0 0", timed_out, out0);
        end
        checks++;
        if (req_a.size() != 8 || wr_a.size() != 8) begin
            errors++; $display("FAIL basic_counts got req=%0d wr=%0d want 8 8", req_a.size(), wr_a.size());
        end
        for (int k = 0; k < req_a.size() && k < 8; k++) begin
            checks++;
            if (req_a[k] !== exp_addr(16'h1A36, k) || req_c[k] != k + 1) begin
                errors++; $display("FAIL basic_req%0d got %h@%0d want %h@%0d", k, req_a[k], req_c[k], exp_addr(16'h1A36, k), k + 1);
            end
        end
        for (int k = 0; k < wr_a.size() && k < sent.size(); k++) begin
            checks++;
            if (wr_a[k] !== exp_addr(16'h1A36, k) || wr_d[k] !== sent[k]) begin
                errors++; $display("FAIL basic_wr%0d got %h/%h want %h/%h", k, wr_a[k], wr_d[k], exp_addr(16'h1A36, k), sent[k]);
            end
        end
        checks++;
        if (tag_cyc != 13 || tag_addr !== 16'h1A30 || tag_wde !== 1'b0 || tag_busy !== 1'b1) begin
            errors++; $display("FAIL basic_tag got cyc=%0d addr=%h wde=%b busy=%b want 13 1a30 0 1", tag_cyc, tag_addr, tag_wde, tag_busy);
        end
        @(negedge clk); miss_detected = 1'b0; #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL basic_busy_fall got %h want 0", all_out);
        end
    endtask

    task automatic test_alternate;
        logic [15:0] a;
        a = 16'($urandom);
        do_fill(a, 1, 1);
        checks++;
        if (timed_out || wr_a.size() != 8) begin
            errors++; $display("FAIL alt_writes got timeout=%b wr=%0d want 0 8", timed_out, wr_a.size());
        end
        for (int k = 0; k < wr_a.size() && k < sent.size(); k++) begin
            checks++;
            if (wr_a[k] !== exp_addr(a, k) || wr_d[k] !== sent[k]) begin
                errors++; $display("FAIL alt_wr%0d got %h/%h want %h/%h", k, wr_a[k], wr_d[k], exp_addr(a, k), sent[k]);
            end
        end
        checks++;
        if (tag_cyc != last_beat + 1 || tag_addr !== exp_base(a)) begin
            errors++; $display("FAIL alt_tag got cyc=%0d addr=%h want %0d %h", tag_cyc, tag_addr, last_beat + 1, exp_base(a));
        end
        @(negedge clk); #1;
        checks++;
        if (fsm_busy !== 1'b0) begin
            errors++; $display("FAIL alt_busy_fall got %b want 0", fsm_busy);
        end
    endtask

    task automatic test_reset_midfill;
        logic [15:0] a;
        int          nwr;
        int          bad;
        a = 16'($urandom); nwr = 0; bad = 0;
        @(negedge clk); miss_detected = 1'b1; miss_address = a; memory_data_valid = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            miss_detected = 1'b0;
            memory_data = 16'($urandom);
            memory_data_valid = (cyc >= 5);
            #1;
            if (write_data_array) begin
                checks++;
                if (fill_address !== exp_addr(a, cyc - 5) || fill_data !== memory_data) begin
                    errors++; $display("FAIL mid_wr got %h/%h want %h/%h", fill_address, fill_data, exp_addr(a, cyc - 5), memory_data);
                end
                nwr++;
            end
        end
        checks++;
        if (nwr != 3) begin
            errors++; $display("FAIL mid_prewrites got %0d want 3", nwr);
        end
        @(negedge clk); rst = 1'b0; memory_data_valid = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL mid_idle got %h want 0", all_out);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memory_data = 16'($urandom);
            memory_data_valid = 1'b1;
            #1;
            if (all_out !== '0) bad++;
        end
        memory_data_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mid_stray got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        do_fill(16'h1A36, 0, 2);
        checks++;
        if (timed_out) begin
            errors++; $display("FAIL b2b_first got timeout want tag");
        end
        do_fill(16'h0040, 0, 3);
        checks++;
        if (out0 !== '0) begin
            errors++; $display("FAIL b2b_idle_gap got %h want 0", out0);
        end
        checks++;
        if (req_a.size() == 0 || req_a[0] !== exp_addr(16'h0040, 0) || req_c[0] != 1) begin
            errors++; $display("FAIL b2b_first_req got n=%0d want %h@1", req_a.size(), exp_addr(16'h0040, 0));
        end
        checks++;
        if (timed_out || wr_a.size() != 8 || tag_addr !== 16'h0040) begin
            errors++; $display("FAIL b2b_second got wr=%0d tag=%h want 8 0040", wr_a.size(), tag_addr);
        end
    endtask

    task automatic test_random;
        logic [15:0] a;
        for (int it = 0; it < 6; it++) begin
            a = (it == 0) ? 16'hFFFE : 16'($urandom);
            do_fill(a, 2, 1 + int'($urandom % 5));
            checks++;
            if (timed_out || out0 !== '0 || req_a.size() != 8 || wr_a.size() != 8) begin
                errors++; $display("FAIL rnd%0d_shape got to=%b out0=%h req=%0d wr=%0d want 0 0 8 8", it, timed_out, out0, req_a.size(), wr_a.size());
            end
            for (int k = 0; k < req_a.size() && k < 8; k++) begin
                checks++;
                if (req_a[k] !== exp_addr(a, k) || req_c[k] != k + 1) begin
                    errors++; $display("FAIL rnd%0d_req%0d got %h@%0d want %h@%0d", it, k, req_a[k], req_c[k], exp_addr(a, k), k + 1);
                end
            end
            for (int k = 0; k < wr_a.size() && k < sent.size(); k++) begin
                checks++;
                if (wr_a[k] !== exp_addr(a, k) || wr_d[k] !== sent[k]) begin
                    errors++; $display("FAIL rnd%0d_wr%0d got %h/%h want %h/%h", it, k, wr_a[k], wr_d[k], exp_addr(a, k), sent[k]);
                end
            end
            checks++;
            if (tag_cyc != last_beat + 1 || tag_addr !== exp_base(a) || tag_wde !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_tag got cyc=%0d addr=%h wde=%b want %0d %h 0", it, tag_cyc, tag_addr, tag_wde, last_beat + 1, exp_base(a));
            end
        end
    endtask

    initial begin
        rst = 1'b0; miss_detected = 1'b0; miss_address = '0;
        memory_data = '0; memory_data_valid = 1'b0;
        test_reset();
        test_fill_basic();
        test_alternate();
        test_reset_midfill();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
